pl_col_chain_stage: RTL and testbench
=====================================

Name: pl_col_chain_stage

Overview:
- Registered, parametrised per-column stage of the BRAM configuration readback chain.
- Each column stage does one of three things:
  - drives its own readback word when it is the selected column or the chain head;
  - OR-merges its own word with the upstream word when the broadcast code is selected;
  - otherwise forwards the upstream word.
- Differences from the flat combinational column mux:
  - the selection is latched per read request;
  - upstream and local words arrive with valid strobes and are held until the merge is ready;
  - output is a registered single-cycle valid pulse;
  - a hung read is caught by a watchdog.

Parameters:
- DATA_W, 36, readback word width.
- COL_W, 10, column-ID width.
- BCAST_COL, 0, PL_COL code that selects OR-broadcast readback.
- TMO_W, 8, watchdog counter width.
- TMO_CYC, 200, WAIT cycles allowed before timeout (1 ≤ TMO_CYC < 2^TMO_W).

Ports:
- CLK_i  in  1  clock.
- RESET_N_i  in  1  synchronous, active-low reset.
- LAST_COL_i  in  1  this stage is the chain head; upstream is ignored.
- COL_ID_i  in  COL_W  static column ID of this stage.
- PL_COL_i  in  COL_W  requested column; sampled on RD_REQ_i.
- RD_REQ_i  in  1  start-of-read strobe.
- MY_COL_DATA_i  in  DATA_W  local BRAM readback word.
- MY_COL_VLD_i  in  1  local word valid, one cycle.
- PREV_COL_DATA_i  in  DATA_W  upstream word.
- PREV_COL_VLD_i  in  1  upstream word valid, one cycle.
- TO_NEXT_COL_DATA_o  out  DATA_W  downstream word; zero when not valid.
- TO_NEXT_COL_VLD_o  out  1  downstream valid pulse.
- BUSY_o  out  1  stage is in WAIT or DONE.
- ERR_TMO_o  out  1  sticky watchdog error.

Behaviour:
- Reset (RESET_N_i low at a rising edge):
  - state = IDLE;
  - all outputs = 0;
  - capture flags, hold registers and watchdog cleared;
  - reset during WAIT/DONE aborts the read with no valid pulse.
- States: IDLE, WAIT, DONE.
- IDLE:
  - on RD_REQ_i, latch PL_COL_i into sel, clear ERR_TMO_o, go to WAIT;
  - MY/PREV valid strobes in IDLE, including the RD_REQ cycle, are ignored.
- Mode is fixed at RD_REQ, first match wins:
  - OWN if sel == COL_ID_i or LAST_COL_i;
  - BCAST if sel == BCAST_COL;
  - PASS otherwise.
- WAIT:
  - MY_COL_VLD_i sets my_got and captures the data; PREV_COL_VLD_i does the same for prev_got.
  - A repeat strobe after capture overwrites the held word.
  - Both strobes may arrive in the same cycle.
  - Completion condition:
    - OWN: my_got;
    - PASS: prev_got;
    - BCAST: my_got && prev_got.
  - Completion is evaluated on the flags including strobes of the current cycle, so a strobe in cycle N gives an output in cycle N+1.
  - On completion, register the output word and go to DONE:
    - OWN: my_hold;
    - PASS: prev_hold;
    - BCAST: my_hold | prev_hold.
- DONE (exactly one cycle):
  - TO_NEXT_COL_VLD_o = 1 and TO_NEXT_COL_DATA_o = the merged word;
  - next cycle: VLD = 0, DATA = 0, state = IDLE, flags cleared.
- Latency: 1 cycle from the last required strobe to VLD.
- Back-to-back reads: RD_REQ_i is accepted in the cycle after DONE. RD_REQ_i in WAIT/DONE is ignored (BUSY_o = 1).
- Watchdog:
  - counts WAIT cycles from 0;
  - if the completion condition is not met in the cycle the counter equals TMO_CYC-1, set ERR_TMO_o and go to IDLE with no valid pulse;
  - completion in the same cycle as expiry wins: output is produced, no error.
- ERR_TMO_o stays high until the next accepted RD_REQ_i or reset.
- COL_ID_i and LAST_COL_i are static; PL_COL_i changes after RD_REQ have no effect.

Test Plan:
- COL_ID=5, RD_REQ with PL_COL=5; MY_VLD two cycles later with data 36'h123456789 → VLD pulse one cycle after the strobe, DATA=36'h123456789; PREV strobes ignored.
- COL_ID=5, PL_COL=7; PREV_VLD with 36'hABCDE → forwarded 36'hABCDE, one-cycle pulse; DATA=0 before and after the pulse.
- PL_COL=0 (BCAST), COL_ID=3: MY=36'h0F0 at cycle 2, PREV=36'h00F at cycle 6 → single pulse at cycle 7, DATA=36'h0FF. Repeat with LAST_COL=1 → pulse after MY only, DATA=36'h0F0.
- Mode priority: PL_COL=0 with COL_ID=0 → OWN; DATA=MY only, no wait on PREV.
- TMO_CYC=4, PASS mode, no PREV strobe → ERR_TMO_o=1 after 4 WAIT cycles, no VLD, BUSY_o=0. Next RD_REQ clears ERR. PREV strobe exactly on the 4th WAIT cycle → normal pulse, ERR stays 0.
- RESET_N_i low mid-WAIT after MY captured → all outputs 0, IDLE; a later MY strobe without RD_REQ produces no output; RD_REQ in WAIT ignored.

Source files
------------

// File: rtl/pl_col_chain_stage_if.sv
// Readback-chain bundle for one column stage: request, local and upstream
// words in; merged downstream word, busy and watchdog error out.
interface pl_col_chain_stage_if #(
  parameter int DATA_W = 36,
  parameter int COL_W  = 10
);
  logic              LAST_COL_i;
  logic [COL_W-1:0]  COL_ID_i;
  logic [COL_W-1:0]  PL_COL_i;
  logic              RD_REQ_i;
  logic [DATA_W-1:0] MY_COL_DATA_i;
  logic              MY_COL_VLD_i;
  logic [DATA_W-1:0] PREV_COL_DATA_i;
  logic              PREV_COL_VLD_i;
  logic [DATA_W-1:0] TO_NEXT_COL_DATA_o;
  logic              TO_NEXT_COL_VLD_o;
  logic              BUSY_o;
  logic              ERR_TMO_o;

  modport master (
    output LAST_COL_i, COL_ID_i, PL_COL_i, RD_REQ_i,
           MY_COL_DATA_i, MY_COL_VLD_i, PREV_COL_DATA_i, PREV_COL_VLD_i,
    input  TO_NEXT_COL_DATA_o, TO_NEXT_COL_VLD_o, BUSY_o, ERR_TMO_o
  );

  modport slave (
    input  LAST_COL_i, COL_ID_i, PL_COL_i, RD_REQ_i,
           MY_COL_DATA_i, MY_COL_VLD_i, PREV_COL_DATA_i, PREV_COL_VLD_i,
    output TO_NEXT_COL_DATA_o, TO_NEXT_COL_VLD_o, BUSY_o, ERR_TMO_o
  );
endinterface

// File: rtl/pl_col_chain_stage.sv
// Registered column stage of the BRAM readback chain: latches the read mode,
// collects local/upstream words, emits one merged valid pulse, with watchdog.
module pl_col_chain_stage #(
  parameter int DATA_W    = 36,
  parameter int COL_W     = 10,
  parameter int BCAST_COL = 0,
  parameter int TMO_W     = 8,
  parameter int TMO_CYC   = 200
) (
  input logic CLK_i,
  input logic RESET_N_i,
  pl_col_chain_stage_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {M_OWN, M_BCAST, M_PASS} mode_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t            state, state_n;
  mode_t             mode, req_mode;
  logic              my_got, prev_got, my_got_n, prev_got_n;
  logic [DATA_W-1:0] my_hold, prev_hold, my_hold_n, prev_hold_n;
  logic [DATA_W-1:0] merged, out_data;
  logic [TMO_W-1:0]  wd_cnt;
  logic              complete, expire, err;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    req_mode    = M_PASS;
    my_got_n    = my_got | bus.MY_COL_VLD_i;
    prev_got_n  = prev_got | bus.PREV_COL_VLD_i;
    my_hold_n   = bus.MY_COL_VLD_i ? bus.MY_COL_DATA_i : my_hold;
    prev_hold_n = bus.PREV_COL_VLD_i ? bus.PREV_COL_DATA_i : prev_hold;
    complete    = 1'b0;
    merged      = '0;

    // Own column / chain head takes priority over the broadcast code.
    if (bus.PL_COL_i == bus.COL_ID_i || bus.LAST_COL_i)
      req_mode = M_OWN;
    else if (bus.PL_COL_i == COL_W'(BCAST_COL))
      req_mode = M_BCAST;

    case (mode)
      M_OWN:   begin complete = my_got_n;              merged = my_hold_n;               end
      M_BCAST: begin complete = my_got_n & prev_got_n; merged = my_hold_n | prev_hold_n; end
      default: begin complete = prev_got_n;            merged = prev_hold_n;             end
    endcase

    expire = (wd_cnt == TMO_LAST) && !complete;

    case (state)
      S_IDLE:  if (bus.RD_REQ_i) state_n = S_WAIT;
      S_WAIT: begin
        if (complete)    state_n = S_DONE;
        else if (expire) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK_i) begin
    if (!RESET_N_i) state <= S_IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge CLK_i) begin
    if (!RESET_N_i) begin
      mode      <= M_OWN;
      my_got    <= 1'b0;
      prev_got  <= 1'b0;
      my_hold   <= '0;
      prev_hold <= '0;
      out_data  <= '0;
      wd_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.RD_REQ_i) begin
          mode   <= req_mode;
          err    <= 1'b0;
          wd_cnt <= '0;
        end
        S_WAIT: begin
          my_got    <= my_got_n;
          prev_got  <= prev_got_n;
          my_hold   <= my_hold_n;
          prev_hold <= prev_hold_n;
          wd_cnt    <= wd_cnt + TMO_W'(1);
          if (complete) begin
            out_data <= merged;
          end else if (expire) begin
            err       <= 1'b1;
            my_got    <= 1'b0;
            prev_got  <= 1'b0;
            my_hold   <= '0;
            prev_hold <= '0;
          end
        end
        default: begin
          out_data  <= '0;
          my_got    <= 1'b0;
          prev_got  <= 1'b0;
          my_hold   <= '0;
          prev_hold <= '0;
        end
      endcase
    end
  end

  assign bus.TO_NEXT_COL_DATA_o = out_data;
  assign bus.TO_NEXT_COL_VLD_o  = (state == S_DONE);
  assign bus.BUSY_o             = (state != S_IDLE);
  assign bus.ERR_TMO_o          = err;

endmodule

// File: tb/tb_pl_col_chain_stage.sv
// Bench for pl_col_chain_stage: directed scenarios plus randomized reads,
// checked against a transaction-level model of the readback rules.
module tb_pl_col_chain_stage;

  localparam int DW = 36;
  localparam int CW = 10;
  localparam int H  = 24;

  localparam int MD_OWN = 0, MD_BCAST = 1, MD_PASS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pl_col_chain_stage_if #(.DATA_W(DW), .COL_W(CW)) bus0 ();
  pl_col_chain_stage_if #(.DATA_W(DW), .COL_W(CW)) bus1 ();

  pl_col_chain_stage #(.DATA_W(DW), .COL_W(CW), .BCAST_COL(0), .TMO_W(8), .TMO_CYC(200)) u_dut (
    .CLK_i(clk), .RESET_N_i(rst_n), .bus(bus0.slave));

  pl_col_chain_stage #(.DATA_W(DW), .COL_W(CW), .BCAST_COL(0), .TMO_W(8), .TMO_CYC(4)) u_dut_tmo (
    .CLK_i(clk), .RESET_N_i(rst_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe schedule indexed by WAIT cycle (0 = first cycle after RD_REQ).
  bit            my_v  [H];
  logic [DW-1:0] my_d  [H];
  bit            prev_v[H];
  logic [DW-1:0] prev_d[H];

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  task automatic clear_sched();
    for (int k = 0; k < H; k++) begin
      my_v[k] = 1'b0; my_d[k] = '0; prev_v[k] = 1'b0; prev_d[k] = '0;
    end
  endtask

  task automatic drive_in(input int d, input bit rd, input logic [CW-1:0] pl,
                          input bit mv, input logic [DW-1:0] md,
                          input bit pv, input logic [DW-1:0] pd);
    if (d == 0) begin
      bus0.RD_REQ_i = rd; bus0.PL_COL_i = pl;
      bus0.MY_COL_VLD_i = mv; bus0.MY_COL_DATA_i = md;
      bus0.PREV_COL_VLD_i = pv; bus0.PREV_COL_DATA_i = pd;
    end else begin
      bus1.RD_REQ_i = rd; bus1.PL_COL_i = pl;
      bus1.MY_COL_VLD_i = mv; bus1.MY_COL_DATA_i = md;
      bus1.PREV_COL_VLD_i = pv; bus1.PREV_COL_DATA_i = pd;
    end
  endtask

  task automatic set_static(input int d, input logic [CW-1:0] col, input bit last);
    if (d == 0) begin bus0.COL_ID_i = col; bus0.LAST_COL_i = last; end
    else        begin bus1.COL_ID_i = col; bus1.LAST_COL_i = last; end
  endtask

  task automatic sample(input int d, output bit vld, output logic [DW-1:0] data,
                        output bit busy, output bit err);
    if (d == 0) begin
      vld = bus0.TO_NEXT_COL_VLD_o; data = bus0.TO_NEXT_COL_DATA_o;
      busy = bus0.BUSY_o; err = bus0.ERR_TMO_o;
    end else begin
      vld = bus1.TO_NEXT_COL_VLD_o; data = bus1.TO_NEXT_COL_DATA_o;
      busy = bus1.BUSY_o; err = bus1.ERR_TMO_o;
    end
  endtask

  // One read against the schedule. req_noise: 0 none, 1 random ignored
  // RD_REQ/PL_COL churn while busy, 2 RD_REQ every busy cycle aimed at OWN.
  task automatic do_read(input string name, input int d, input logic [CW-1:0] col,
                         input bit last, input logic [CW-1:0] pl, input int req_noise);
    int mode, fm, fp, c, tmo_cyc, last_ign;
    bit timeout, vld, busy, err, e_vld, e_busy, e_err, rd;
    logic [DW-1:0] data, e_word, e_data, my_last, prev_last;
    logic [CW-1:0] pl_drv;

    // Model: mode from the selection rules, completion from first strobes.
    if (pl == col || last) mode = MD_OWN;
    else if (pl == '0)     mode = MD_BCAST;
    else                   mode = MD_PASS;

    fm = -1; fp = -1;
    for (int k = H - 1; k >= 0; k--) begin
      if (my_v[k])   fm = k;
      if (prev_v[k]) fp = k;
    end
    case (mode)
      MD_OWN:   c = fm;
      MD_PASS:  c = fp;
      default:  c = (fm < 0 || fp < 0) ? -1 : ((fm > fp) ? fm : fp);
    endcase
    tmo_cyc = (d == 0) ? 200 : 4;
    timeout = (c < 0) || (c >= tmo_cyc);

    my_last = '0; prev_last = '0;
    for (int k = 0; k < H; k++) begin
      if (!timeout && k <= c && my_v[k])   my_last = my_d[k];
      if (!timeout && k <= c && prev_v[k]) prev_last = prev_d[k];
    end
    case (mode)
      MD_OWN:  e_word = my_last;
      MD_PASS: e_word = prev_last;
      default: e_word = my_last | prev_last;
    endcase
    last_ign = timeout ? tmo_cyc - 1 : c;

    set_static(d, col, last);
    @(posedge clk); #1;
    // Strobes on the request cycle must be ignored.
    if (req_noise != 0)
      drive_in(d, 1'b1, pl, 1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)), rnd_word());
    else
      drive_in(d, 1'b1, pl, 1'b0, '0, 1'b0, '0);

    for (int j = 1; j <= H + 3; j++) begin
      @(posedge clk); #1;
      sample(d, vld, data, busy, err);
      if (timeout) begin
        e_vld = 1'b0; e_busy = (j <= tmo_cyc); e_err = (j >= tmo_cyc + 1);
      end else begin
        e_vld = (j == c + 2); e_busy = (j <= c + 2); e_err = 1'b0;
      end
      e_data = e_vld ? e_word : '0;

      n_checks++;
      if (vld !== e_vld) begin
        n_fail++; $display("FAIL %s vld j=%0d: got %0b exp %0b", name, j, vld, e_vld);
      end
      n_checks++;
      if (data !== e_data) begin
        n_fail++; $display("FAIL %s data j=%0d: got %h exp %h", name, j, data, e_data);
      end
      n_checks++;
      if (busy !== e_busy) begin
        n_fail++; $display("FAIL %s busy j=%0d: got %0b exp %0b", name, j, busy, e_busy);
      end
      n_checks++;
      if (err !== e_err) begin
        n_fail++; $display("FAIL %s err j=%0d: got %0b exp %0b", name, j, err, e_err);
      end

      if (j - 1 < H) begin
        rd = 1'b0; pl_drv = pl;
        if (req_noise == 1) begin
          pl_drv = CW'($urandom_range(0, 7));
          rd = (j - 1 <= last_ign) && ($urandom_range(0, 3) == 0);
        end else if (req_noise == 2) begin
          pl_drv = col;
          rd = (j - 1 <= last_ign);
        end
        drive_in(d, rd, pl_drv, my_v[j-1], my_d[j-1], prev_v[j-1], prev_d[j-1]);
      end else begin
        drive_in(d, 1'b0, pl, 1'b0, '0, 1'b0, '0);
      end
    end
    drive_in(d, 1'b0, pl, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    bit vld, busy, err;
    logic [DW-1:0] data;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d, vld, data, busy, err);
      n_checks++;
      if ({vld, busy, err} !== 3'b000) begin
        n_fail++; $display("FAIL reset flags dut%0d: got %b exp 000", d, {vld, busy, err});
      end
      n_checks++;
      if (data !== '0) begin
        n_fail++; $display("FAIL reset data dut%0d: got %h exp 0", d, data);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_own();
    clear_sched();
    my_v[1] = 1'b1;   my_d[1] = 36'h123456789;
    prev_v[0] = 1'b1; prev_d[0] = 36'hFFFFFFFFF;
    prev_v[4] = 1'b1; prev_d[4] = 36'h111111111;
    do_read("own", 0, 10'd5, 1'b0, 10'd5, 0);
  endtask

  task automatic test_pass();
    clear_sched();
    prev_v[2] = 1'b1; prev_d[2] = 36'hABCDE;
    my_v[0] = 1'b1;   my_d[0] = 36'h987654321;
    do_read("pass", 0, 10'd5, 1'b0, 10'd7, 0);
  endtask

  task automatic test_bcast();
    clear_sched();
    my_v[1] = 1'b1;   my_d[1] = 36'h0F0;
    prev_v[5] = 1'b1; prev_d[5] = 36'h00F;
    do_read("bcast", 0, 10'd3, 1'b0, 10'd0, 0);
    do_read("bcast_head", 0, 10'd3, 1'b1, 10'd0, 0);
  endtask

  task automatic test_priority();
    clear_sched();
    my_v[1] = 1'b1;   my_d[1] = 36'h555;
    prev_v[0] = 1'b1; prev_d[0] = 36'hAAA;
    prev_v[6] = 1'b1; prev_d[6] = 36'h0C0;
    do_read("prio_own", 0, 10'd0, 1'b0, 10'd0, 0);
  endtask

  task automatic test_watchdog();
    clear_sched();
    my_v[1] = 1'b1; my_d[1] = 36'h123;
    do_read("tmo_expire", 1, 10'd5, 1'b0, 10'd7, 0);
    clear_sched();
    prev_v[3] = 1'b1; prev_d[3] = 36'h3C3C3C3C3;
    do_read("tmo_edge_win", 1, 10'd5, 1'b0, 10'd7, 0);
    clear_sched();
    prev_v[4] = 1'b1; prev_d[4] = 36'h777;
    do_read("tmo_late", 1, 10'd5, 1'b0, 10'd7, 0);
  endtask

  task automatic test_reset_mid_wait();
    bit vld, busy, err;
    logic [DW-1:0] data;
    set_static(0, 10'd3, 1'b0);
    @(posedge clk); #1;
    drive_in(0, 1'b1, 10'd0, 1'b0, '0, 1'b0, '0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 10'd0, 1'b1, 36'h0F0, 1'b0, '0);
    @(posedge clk); #1;
    drive_in(0, 1'b0, 10'd0, 1'b0, '0, 1'b0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sample(0, vld, data, busy, err);
    n_checks++;
    if ({vld, busy, err} !== 3'b000 || data !== '0) begin
      n_fail++; $display("FAIL mid_reset: got flags %b data %h exp 000/0", {vld, busy, err}, data);
    end
    for (int j = 0; j < 6; j++) begin
      drive_in(0, 1'b0, 10'd0, (j % 2) == 0, rnd_word(), (j % 2) == 1, rnd_word());
      @(posedge clk); #1;
      sample(0, vld, data, busy, err);
      n_checks++;
      if ({vld, busy} !== 2'b00 || data !== '0) begin
        n_fail++; $display("FAIL idle_strobe j=%0d: got vld %0b busy %0b data %h exp 0/0/0", j, vld, busy, data);
      end
    end
    drive_in(0, 1'b0, 10'd0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_req_in_wait();
    clear_sched();
    for (int k = 0; k < 6; k++) begin my_v[k] = 1'b1; my_d[k] = rnd_word(); end
    prev_v[5] = 1'b1; prev_d[5] = 36'h246813579;
    do_read("req_in_wait", 0, 10'd4, 1'b0, 10'd9, 2);
  endtask

  task automatic test_random();
    int d;
    logic [CW-1:0] col, pl;
    bit last;
    for (int it = 0; it < 60; it++) begin
      d    = int'($urandom_range(0, 1));
      col  = CW'($urandom_range(0, 7));
      pl   = CW'($urandom_range(0, 7));
      last = ($urandom_range(0, 7) == 0);
      clear_sched();
      my_v[$urandom_range(0, 12)]   = 1'b1;
      prev_v[$urandom_range(0, 12)] = 1'b1;
      for (int k = 0; k < H; k++) begin
        if ($urandom_range(0, 5) == 0) my_v[k] = 1'b1;
        if ($urandom_range(0, 5) == 0) prev_v[k] = 1'b1;
        my_d[k]   = rnd_word();
        prev_d[k] = rnd_word();
      end
      do_read("random", d, col, last, pl, 1);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      set_static(d, '0, 1'b0);
      drive_in(d, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    end
    test_reset();
    test_own();
    test_pass();
    test_bcast();
    test_priority();
    test_watchdog();
    test_reset_mid_wait();
    test_req_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
